// File: rtl/alu_issue_stage.sv
// Issue stage for a combinational ALU: buffers commands in a FIFO, presents one
// command's operands to the ALU, and holds the captured result until it is taken.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [2:0]        cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic [2:0]        res_op_o,
  output logic [15:0]       done_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMD_W = 2 * DATA_W + 3;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [CMD_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [CMD_W-1:0]  head;
  logic              fifo_nonempty;
  logic              push;
  logic              pop;
  logic              handoff;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] res_q;
  logic [2:0]        res_op_q;
  logic [15:0]       done_cnt;

  assign fifo_nonempty = (count != '0);
  assign cmd_ready_o   = (count < FULL_CNT);
  assign push          = cmd_valid_i && cmd_ready_o;
  assign head          = fifo_mem[rd_ptr];
  assign handoff       = (state == HOLD) && res_ready_i;

  // Only entries already stored may be popped, so a command never skips the FIFO.
  assign pop = fifo_nonempty && ((state == IDLE) || handoff);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_nonempty) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (res_ready_i) state_nxt = fifo_nonempty ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is left unreset: pointers and occupancy alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op_i, cmd_b_i, cmd_a_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      res_q    <= '0;
      res_op_q <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr                  <= rd_ptr + PTR_ONE;
        {op_code, op_b, op_a}   <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (state == EXEC) begin
        res_q    <= alu_res_i;
        res_op_q <= op_code;
      end

      if (handoff) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

  assign alu_a_o     = op_a;
  assign alu_b_o     = op_b;
  assign alu_op_o    = op_code;
  assign res_valid_o = (state == HOLD);
  assign res_o       = res_q;
  assign res_op_o    = res_op_q;
  assign done_cnt_o  = done_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, corner sequences,
// and randomized traffic against an in-order result scoreboard.
module tb_alu_issue_stage;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_res;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_o;
  logic [2:0]  res_op;
  logic [15:0] done_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [10:0] sb [$];
  logic [15:0] model_cnt;
  logic        held;
  logic [10:0] held_val;

  vec_t        vecs [9];
  logic [7:0]  exp_q [$];
  logic [7:0]  r;
  logic [2:0]  ro;
  logic [15:0] base;
  int unsigned acc;
  int unsigned n;
  int unsigned last;
  int unsigned stale;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b;
      3'd3:    return a >> b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

  alu_issue_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_op_i    (cmd_op),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_res_i   (alu_res),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res_o),
    .res_op_o    (res_op),
    .done_cnt_o  (done_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int unsigned k;
    k = 0;
    while (!res_valid && k < 10) begin
      step();
      k++;
    end
    chk("res_valid_timeout", 32'(res_valid), 1);
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output logic [7:0] rr, output logic [2:0] rop);
    cmd_a = a; cmd_b = b; cmd_op = op;
    cmd_valid = 1'b1;
    res_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    wait_valid();
    rr  = res_o;
    rop = res_op;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic observe();
    logic [10:0] e;
    if (held) begin
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_stable", 32'({res_op, res_o}), 32'(held_val));
    end
    if (res_valid && res_ready) begin
      chk("handoff_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rand_res", 32'({res_op, res_o}), 32'(e));
      end
      model_cnt = model_cnt + 16'd1;
    end
    if (cmd_valid && cmd_ready) sb.push_back({cmd_op, alu_f(cmd_a, cmd_b, cmd_op)});
    chk("inflight_cap", 32'(sb.size() <= DEPTH + 1), 1);
    held     = res_valid && !res_ready;
    held_val = {res_op, res_o};
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h00, 8'h01, 3'd1, 8'hFF};
    vecs[1] = '{8'h5A, 8'h5A, 3'd7, 8'h01};
    vecs[2] = '{8'h81, 8'h01, 3'd2, 8'h02};
    vecs[3] = '{8'hFF, 8'h01, 3'd0, 8'h00};
    vecs[4] = '{8'h80, 8'h03, 3'd3, 8'h10};
    vecs[5] = '{8'hF0, 8'h3C, 3'd4, 8'h30};
    vecs[6] = '{8'hF0, 8'h0F, 3'd5, 8'hFF};
    vecs[7] = '{8'hAA, 8'hFF, 3'd6, 8'h55};
    vecs[8] = '{8'h5A, 8'h5B, 3'd7, 8'h00};

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_res", 32'({res_op, res_o}), 0);
    chk("rst_operands", 32'({alu_op, alu_b, alu_a}), 0);

    // Single ADD: valid two edges after acceptance, counted one edge later.
    cmd_a = 8'h0F; cmd_b = 8'h01; cmd_op = 3'd0; cmd_valid = 1'b1; res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("lat_e0_valid", 32'(res_valid), 0);
    step();
    chk("lat_e1_valid", 32'(res_valid), 0);
    chk("lat_e1_alu_a", 32'(alu_a), 32'h0F);
    step();
    chk("lat_e2_valid", 32'(res_valid), 1);
    chk("lat_e2_res", 32'(res_o), 32'h10);
    chk("lat_e2_op", 32'(res_op), 0);
    chk("lat_e2_cnt", 32'(done_cnt), 0);
    step();
    chk("lat_e3_cnt", 32'(done_cnt), 1);
    chk("lat_e3_valid", 32'(res_valid), 0);
    res_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].op, r, ro);
      chk($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_op", i), 32'(ro), 32'(vecs[i].op));
      take_result();
    end

    // Back-pressure: six offers, DEPTH+1 accepted, then drained in order.
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 8'(i * 16 + 1); cmd_b = 8'(i); cmd_op = 3'd0; cmd_valid = 1'b1;
      if (cmd_ready) begin
        exp_q.push_back(cmd_a + cmd_b);
        acc++;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_ready_full", 32'(cmd_ready), 0);
    res_ready = 1'b1;
    n = 0; last = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) begin
        chk("bp_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk($sformatf("bp_res%0d", n), 32'(res_o), 32'(exp_q.pop_front()));
        if (n > 0) chk("bp_spacing", c - last, 2);
        last = c;
        n++;
      end
      step();
    end
    chk("bp_count", n, 5);
    chk("bp_idle", 32'(res_valid), 0);
    res_ready = 1'b0;

    // Held result with ready toggling 0/1/0.
    run_one(8'h3C, 8'h0F, 3'd6, r, ro);
    chk("tog_res", 32'(r), 32'h33);
    base = done_cnt;
    step();
    chk("tog_stable1", 32'({res_valid, res_o}), 32'({1'b1, r}));
    step();
    chk("tog_stable2", 32'({res_valid, res_o}), 32'({1'b1, r}));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    step();
    chk("tog_one_handoff", 32'(done_cnt), 32'(base + 16'd1));
    chk("tog_idle", 32'(res_valid), 0);

    // Reset while holding a result with three commands queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 8'(i + 2); cmd_b = 8'h07; cmd_op = 3'd4; cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    step();
    chk("pre_rst_hold", 32'(res_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_cnt", 32'(done_cnt), 0);
    chk("mid_rst_res", 32'(res_o), 0);
    res_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (res_valid) stale++;
      step();
    end
    chk("mid_rst_no_stale", stale, 0);
    chk("mid_rst_cnt_after", 32'(done_cnt), 0);

    // Randomized traffic against the in-order scoreboard.
    model_cnt = 16'd0;
    held = 1'b0;
    held_val = '0;
    for (int c = 0; c < 500; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom_range(0, 9));
      cmd_op    = 3'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      observe();
      step();
      chk("rand_done_cnt", 32'(done_cnt), 32'(model_cnt));
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      observe();
      step();
    end
    chk("drain_empty", sb.size(), 0);
    chk("drain_done_cnt", 32'(done_cnt), 32'(model_cnt));
    chk("drain_idle", 32'(res_valid), 0);
    res_ready = 1'b0;

    // Counter wrap: preload near the top, then two real handoffs.
    force dut.done_cnt = 16'hFFFE;
    #1;
    release dut.done_cnt;
    chk("wrap_preload", 32'(done_cnt), 32'hFFFE);
    run_one(8'h01, 8'h01, 3'd0, r, ro);
    take_result();
    chk("wrap_ffff", 32'(done_cnt), 32'hFFFF);
    run_one(8'h02, 8'h01, 3'd1, r, ro);
    chk("wrap_res", 32'(r), 32'h01);
    take_result();
    chk("wrap_zero", 32'(done_cnt), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
